// File: rtl/ps2_ascii_rx.sv
// ps2_ascii_rx: PS/2 keyboard receiver, Set-2 scancode decoder, ASCII strobe source.
// Latency: key_valid two clk cycles after the stop-bit falling edge is seen (E+2), FIFO empty.
// Backpressure: none accepted; a full scancode FIFO drops the byte and sets sticky overflow.
//
// Ports:
//   clk, reset (async, active low)    system clock and reset
//   ps2_clk, ps2_data                 raw PS/2 lines, asynchronous to clk
//   key_out / key_valid               ASCII byte (held) and its one-cycle strobe
//   shift_state                       Shift held
//   frame_err                         one-cycle pulse per rejected frame
//   overflow                          sticky, a good byte was lost to a full FIFO
// Optional: define PS2_CAPS_LOCK_EN to make scancode 58 toggle Caps Lock for letters.

module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         drop
);
  // Generic synchronous FIFO, one write and one read port.
  // Latency: a pushed entry is readable the cycle after the push.
  // Backpressure: push while full is dropped (drop pulse) unless a pop frees the slot.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, do_wr, do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_rd   = pop_rdy & ~empty;
  assign do_wr   = push_vld & (~full | do_rd);
  assign drop    = push_vld & full & ~do_rd;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module ps2_ascii_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_out,
  output logic       key_valid,
  output logic       shift_state,
  output logic       frame_err,
  output logic       overflow
);
  // PS/2 deframer + scancode FIFO + make/break decoder driving the video-memory write port.
  // Latency: stop-bit edge in cycle E -> FIFO entry at E+1 -> key_valid at E+2.
  // Backpressure: none; the keyboard cannot be stalled, bytes beyond FIFO_DEPTH are dropped.
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} dec_state_t;

  // ---------------- receiver ----------------
  logic [2:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;      // bits 0..9 of the frame once bit 9 has arrived
  logic [TW-1:0] idle_cnt;
  logic          fall, frame_done, frame_ok;

  assign fall       = clk_sync[2] & ~clk_sync[1];
  assign frame_done = fall & (bit_cnt == 4'd10);
  // start low, odd parity over data+parity, stop (sampled now) high
  assign frame_ok   = ~shreg[0] & (^shreg[9:1]) & dat_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync  <= 3'b111;   // idle-high lines so reset release never looks like an edge
      dat_sync  <= 2'b11;
      bit_cnt   <= '0;
      shreg     <= '0;
      idle_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      dat_sync  <= {dat_sync[0], ps2_data};
      frame_err <= frame_done & ~frame_ok;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {dat_sync[1], shreg[9:1]};
        end
      end else if (bit_cnt != 4'd0) begin
        // stalled partial frame: give up silently and resync on the next edge
        if (idle_cnt == TO_LAST) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // ---------------- scancode FIFO ----------------
  logic       fifo_rd, fifo_empty, fifo_drop;
  logic [7:0] fifo_dat;

  assign fifo_rd = ~fifo_empty;

  ps2_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (frame_done & frame_ok),
    .push_dat (shreg[8:1]),
    .pop_rdy  (fifo_rd),
    .pop_dat  (fifo_dat),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

  // ---------------- decoder ----------------
  // {is_letter, mapped, ascii (lowercase for letters)}
  function automatic logic [9:0] lookup(input logic [7:0] b);
    case (b)
      8'h1C: lookup = {2'b11, 8'h61}; 8'h32: lookup = {2'b11, 8'h62};
      8'h21: lookup = {2'b11, 8'h63}; 8'h23: lookup = {2'b11, 8'h64};
      8'h24: lookup = {2'b11, 8'h65}; 8'h2B: lookup = {2'b11, 8'h66};
      8'h34: lookup = {2'b11, 8'h67}; 8'h33: lookup = {2'b11, 8'h68};
      8'h43: lookup = {2'b11, 8'h69}; 8'h3B: lookup = {2'b11, 8'h6A};
      8'h42: lookup = {2'b11, 8'h6B}; 8'h4B: lookup = {2'b11, 8'h6C};
      8'h3A: lookup = {2'b11, 8'h6D}; 8'h31: lookup = {2'b11, 8'h6E};
      8'h44: lookup = {2'b11, 8'h6F}; 8'h4D: lookup = {2'b11, 8'h70};
      8'h15: lookup = {2'b11, 8'h71}; 8'h2D: lookup = {2'b11, 8'h72};
      8'h1B: lookup = {2'b11, 8'h73}; 8'h2C: lookup = {2'b11, 8'h74};
      8'h3C: lookup = {2'b11, 8'h75}; 8'h2A: lookup = {2'b11, 8'h76};
      8'h1D: lookup = {2'b11, 8'h77}; 8'h22: lookup = {2'b11, 8'h78};
      8'h35: lookup = {2'b11, 8'h79}; 8'h1A: lookup = {2'b11, 8'h7A};
      8'h45: lookup = {2'b01, 8'h30}; 8'h16: lookup = {2'b01, 8'h31};
      8'h1E: lookup = {2'b01, 8'h32}; 8'h26: lookup = {2'b01, 8'h33};
      8'h25: lookup = {2'b01, 8'h34}; 8'h2E: lookup = {2'b01, 8'h35};
      8'h36: lookup = {2'b01, 8'h36}; 8'h3D: lookup = {2'b01, 8'h37};
      8'h3E: lookup = {2'b01, 8'h38}; 8'h46: lookup = {2'b01, 8'h39};
      8'h29: lookup = {2'b01, 8'h20};   // space
      8'h5A: lookup = {2'b01, 8'h0A};   // Enter -> newline
      8'h66: lookup = {2'b01, 8'h08};   // backspace
      default: lookup = 10'd0;
    endcase
  endfunction

  dec_state_t state, state_nxt;
  logic       shift_nxt, emit, upper, is_shift;
  logic [7:0] emit_code;
  logic [9:0] map;

  assign map      = lookup(fifo_dat);
  assign is_shift = (fifo_dat == 8'h12) | (fifo_dat == 8'h59);

`ifdef PS2_CAPS_LOCK_EN
  logic caps, caps_nxt;
  assign upper = shift_state ^ caps;
`else
  assign upper = shift_state;
`endif

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_state;
    emit      = 1'b0;
    emit_code = key_out;
`ifdef PS2_CAPS_LOCK_EN
    caps_nxt  = caps;
`endif
    if (fifo_rd) begin
      case (state)
        IDLE: begin
          if (fifo_dat == 8'hF0)      state_nxt = BRK;
          else if (fifo_dat == 8'hE0) state_nxt = EXT;
          else if (is_shift)          shift_nxt = 1'b1;
`ifdef PS2_CAPS_LOCK_EN
          else if (fifo_dat == 8'h58) caps_nxt = ~caps;
`endif
          else if (map[8]) begin
            emit      = 1'b1;
            emit_code = (map[9] & upper) ? (map[7:0] ^ 8'h20) : map[7:0];
          end
        end
        BRK: begin
          if (is_shift) shift_nxt = 1'b0;
          state_nxt = IDLE;
        end
        EXT:     state_nxt = (fifo_dat == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shift_state <= 1'b0;
      key_out     <= '0;
      key_valid   <= 1'b0;
      overflow    <= 1'b0;
`ifdef PS2_CAPS_LOCK_EN
      caps        <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      shift_state <= shift_nxt;
      key_valid   <= emit;
      if (emit) key_out <= emit_code;
      overflow    <= overflow | fifo_drop;
`ifdef PS2_CAPS_LOCK_EN
      caps        <= caps_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_ps2_ascii_rx.sv
module tb_ps2_ascii_rx;
  localparam int H = 8;   // PS/2 half period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_out;
  logic       key_valid, shift_state, frame_err, overflow;

  ps2_ascii_rx dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_out(key_out), .key_valid(key_valid), .shift_state(shift_state),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int ferr_n = 0;
  int ferr_cyc = 0;
  logic [7:0] kv_q[$];
  int         kv_cyc_q[$];
  logic [7:0] exp_q[$];

  // Set-2 codes listed alphabetically / numerically; ASCII is base + index
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
  logic [7:0] special_codes [3] = '{8'h29, 8'h5A, 8'h66};
  logic [7:0] special_ascii [3] = '{8'h20, 8'h0A, 8'h08};
  logic [7:0] unmapped_codes [4] = '{8'h05, 8'h76, 8'h0D, 8'h14};

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (key_valid) begin
      kv_q.push_back(key_out);
      kv_cyc_q.push_back(cyc);
    end
    if (frame_err) begin
      ferr_n++;
      ferr_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_keys(input string tag);
    check({tag, "_count"}, kv_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < kv_q.size(); i++) check(tag, kv_q[i], exp_q[i]);
    kv_q.delete();
    kv_cyc_q.delete();
    exp_q.delete();
  endtask

  // fault: 0 none, 1 parity flipped, 2 start bit high, 3 stop bit low
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input int fault);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    if (fault == 1) f[9] = ~f[9];
    if (fault == 2) f[0] = 1'b1;
    if (fault == 3) f[10] = 1'b0;
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = f[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      fall_cyc = cyc;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 0), 11);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    kv_q.delete();
    kv_cyc_q.delete();
  endtask

  initial begin
    int fe0, k, idx;
    logic m_shift;
    logic [7:0] m_shift_code;
    logic [7:0] tok[$];

    // reset state
    repeat (4) @(negedge clk);
    check("rst_key_out", key_out, 8'h00);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_shift", shift_state, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // single make, latency from the stop-bit edge
    send_byte(8'h1C);
    check("lat_n", kv_cyc_q.size(), 1);
    if (kv_cyc_q.size() > 0) check("lat_cycles", kv_cyc_q[0] - fall_cyc, 4);
    check("lat_ferr", ferr_n, 0);
    exp_q.push_back(8'h61);
    check_keys("a_make");

    // shift make / break
    send_byte(8'h12);  check("shift_on", shift_state, 1'b1);
    send_byte(8'h1C);  check("shift_held", shift_state, 1'b1);
    send_byte(8'hF0);  send_byte(8'h1C);
    check("shift_still", shift_state, 1'b1);
    send_byte(8'hF0);  send_byte(8'h12);
    check("shift_off", shift_state, 1'b0);
    send_byte(8'h1C);
    exp_q.push_back(8'h41); exp_q.push_back(8'h61);
    check_keys("shift_seq");

    // corrupted frames each give one frame_err pulse and no key
    for (int f = 1; f <= 3; f++) begin
      fe0 = ferr_n;
      send_bits(mk_frame(8'h1C, f), 11);
      repeat (4) @(negedge clk);
      check("ferr_pulse", ferr_n, fe0 + 1);
      check("ferr_cycle", ferr_cyc - fall_cyc, 3);
      check_keys("ferr_nokey");
    end
    send_byte(8'h5A);
    exp_q.push_back(8'h0A);
    check_keys("enter");

    // partial frame abandoned by timeout
    fe0 = ferr_n;
    send_bits(mk_frame(8'h1C, 0), 4);
    repeat (5100) @(negedge clk);
    send_byte(8'h29);
    check("timeout_noerr", ferr_n, fe0);
    exp_q.push_back(8'h20);
    check_keys("timeout_space");

    // extended make and break are ignored
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'h1C);
    exp_q.push_back(8'h61);
    check_keys("ext_ignore");

    // digits and controls ignore shift
    send_byte(8'h12); send_byte(8'h16); send_byte(8'h46);
    send_byte(8'h66); send_byte(8'hF0); send_byte(8'h12);
    exp_q.push_back(8'h31); exp_q.push_back(8'h39); exp_q.push_back(8'h08);
    check_keys("digits_shift");

`ifdef PS2_CAPS_LOCK_EN
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58); send_byte(8'h1C);
    send_byte(8'h12); send_byte(8'h1C); send_byte(8'h16);
    send_byte(8'hF0); send_byte(8'h12);
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58); send_byte(8'h1C);
    exp_q.push_back(8'h41); exp_q.push_back(8'h61); exp_q.push_back(8'h31);
    exp_q.push_back(8'h61);
    check_keys("caps");
`else
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58); send_byte(8'h1C);
    exp_q.push_back(8'h61);
    check_keys("caps_off");
`endif

    // overflow with the decoder stalled
    do_reset();
    force dut.fifo_rd = 1'b0;
    for (int i = 0; i < 9; i++) send_byte(letter_codes[i]);
    check("ovf_set", overflow, 1'b1);
    check("ovf_stalled_nokey", kv_q.size(), 0);
    release dut.fifo_rd;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h61 + 8'(i));
    check_keys("ovf_order");
    check("ovf_sticky", overflow, 1'b1);

    do_reset();
    check("ovf_cleared", overflow, 1'b0);
    for (int i = 0; i < 9; i++) send_byte(letter_codes[i]);
    check("no_ovf", overflow, 1'b0);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h61 + 8'(i));
    check_keys("no_ovf_keys");

    // reset in the middle of a frame and of a sequence
    send_byte(8'h12);
    send_bits(mk_frame(8'h32, 0), 5);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_shift", shift_state, 1'b0);
    check("midrst_key_out", key_out, 8'h00);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    kv_q.delete(); kv_cyc_q.delete();
    send_byte(8'h1C);
    exp_q.push_back(8'h61);
    check_keys("midrst_decode");

    // randomized key events against a token-level model
    m_shift = 1'b0;
    m_shift_code = 8'h12;
    for (int t = 0; t < 40; t++) begin
      tok.delete();
      k = $urandom_range(0, 8);
      case (k)
        0, 1: begin
          idx = $urandom_range(0, 25);
          tok.push_back(letter_codes[idx]);
          exp_q.push_back((m_shift ? 8'h41 : 8'h61) + 8'(idx));
        end
        2: begin
          idx = $urandom_range(0, 25);
          tok.push_back(8'hF0); tok.push_back(letter_codes[idx]);
        end
        3: begin
          idx = $urandom_range(0, 9);
          tok.push_back(digit_codes[idx]);
          exp_q.push_back(8'h30 + 8'(idx));
        end
        4: begin
          if (m_shift) begin
            tok.push_back(8'hF0); tok.push_back(m_shift_code);
            m_shift = 1'b0;
          end else begin
            m_shift_code = ($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59;
            tok.push_back(m_shift_code);
            m_shift = 1'b1;
          end
        end
        5: begin
          idx = $urandom_range(0, 25);
          tok.push_back(8'hE0);
          if ($urandom_range(0, 1) == 1) tok.push_back(8'hF0);
          tok.push_back(letter_codes[idx]);
        end
        6: begin
          idx = $urandom_range(0, 2);
          tok.push_back(special_codes[idx]);
          exp_q.push_back(special_ascii[idx]);
        end
        7: begin
          idx = $urandom_range(0, 3);
          tok.push_back(unmapped_codes[idx]);
        end
        default: begin
          idx = $urandom_range(0, 3);
          tok.push_back(8'hF0); tok.push_back(unmapped_codes[idx]);
        end
      endcase
      foreach (tok[j]) send_byte(tok[j]);
      check("rand_shift", shift_state, m_shift);
      check_keys("rand_keys");
    end
    check("rand_no_ovf", overflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
